// File: rtl/io_pkg.sv
// Shared constants for the CPU IO window: register offsets, default base address
// and the load-handshake state encoding.
package io_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FC00;

    localparam logic [7:0] OFF_SW       = 8'h00;
    localparam logic [7:0] OFF_LED      = 8'h10;
    localparam logic [7:0] OFF_SEG      = 8'h20;
    localparam logic [7:0] OFF_BASE_SEL = 8'h30;
    localparam logic [7:0] OFF_BTN      = 8'h40;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_PRESS = 2'd1,
        ST_DONE       = 2'd2
    } io_state_t;

endpackage

// File: rtl/io_debounce.sv
// Confirm-button conditioning: 2-flop synchronizer, optional debounce counter
// (enabled by macro IO_DEBOUNCE_EN) and rising-edge detector on the clean level.
module io_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic level_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

`ifdef IO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;

    // The level follows only after the input has disagreed with it for a full
    // run of DEBOUNCE_CYCLES cycles; any agreement restarts the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_2 != level) begin
            if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end
`else
    assign level = sync_2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/io_bus_ctrl.sv
// CPU IO window: switch load with wait-for-confirm handshake, LED/seg store pulses,
// display radix register and button status. Debounce enabled by IO_DEBOUNCE_EN.
module io_bus_ctrl
    import io_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 20000,
    parameter logic [31:0] IO_BASE         = IO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] wdata,
    input  logic [15:0] sw,
    input  logic        btn_confirm,
    output logic [31:0] rdata,
    output logic        io_hit,
    output logic        stall,
    output logic        led_ctrl,
    output logic        seg_ctrl,
    output logic [31:0] io_wdata,
    output logic        e_read,
    output logic        base_sel
);

    io_state_t   state;
    io_state_t   state_n;
    logic [7:0]  offset;
    logic        wr_acc;
    logic        rd_acc;
    logic        rd_sw;
    logic [15:0] sw_s1;
    logic [15:0] sw_s2;
    logic [31:0] cap_data;
    logic        btn_level;
    logic        btn_rise;

    io_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_confirm),
        .level(btn_level),
        .rise (btn_rise)
    );

    assign offset = addr[7:0];
    assign io_hit = (addr[31:8] == IO_BASE[31:8]);
    // A simultaneous store wins; the load half of the access is dropped.
    assign wr_acc = mem_write & io_hit;
    assign rd_acc = mem_read & ~mem_write & io_hit;
    assign rd_sw  = rd_acc & (offset == OFF_SW);

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:       if (rd_sw) state_n = ST_WAIT_PRESS;
            ST_WAIT_PRESS: if (btn_rise) state_n = ST_DONE;
            ST_DONE:       state_n = ST_IDLE;
            default:       state_n = ST_IDLE;
        endcase
    end

    assign stall  = (state == ST_WAIT_PRESS) | ((state == ST_IDLE) & rd_sw);
    assign e_read = (state == ST_WAIT_PRESS);

    always_comb begin
        rdata = 32'h0;
        if (state == ST_DONE) begin
            rdata = cap_data;
        end else if (rd_acc && offset == OFF_BTN) begin
            rdata = {31'h0, btn_level};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sw_s1    <= 16'h0;
            sw_s2    <= 16'h0;
            cap_data <= 32'h0;
            led_ctrl <= 1'b0;
            seg_ctrl <= 1'b0;
            io_wdata <= 32'h0;
            base_sel <= 1'b0;
        end else begin
            state    <= state_n;
            sw_s1    <= sw;
            sw_s2    <= sw_s1;
            led_ctrl <= wr_acc && (offset == OFF_LED);
            seg_ctrl <= wr_acc && (offset == OFF_SEG);
            if (wr_acc && (offset == OFF_LED || offset == OFF_SEG)) begin
                io_wdata <= wdata;
            end
            if (wr_acc && offset == OFF_BASE_SEL) begin
                base_sel <= wdata[0];
            end
            if (state == ST_WAIT_PRESS && btn_rise) begin
                cap_data <= {16'h0, sw_s2};
            end
        end
    end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed bench for io_bus_ctrl: cycle model of the IO window checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_io_bus_ctrl;

    localparam int          DB     = 4;
    localparam logic [31:0] BASE   = 32'hFFFF_FC00;
    localparam int          MAXC   = 4096;
`ifdef IO_DEBOUNCE_EN
    localparam int          DONE_I = 9;
`else
    localparam int          DONE_I = 3;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] wdata;
    logic [15:0] sw;
    logic        btn_confirm;
    logic [31:0] rdata;
    logic        io_hit;
    logic        stall;
    logic        led_ctrl;
    logic        seg_ctrl;
    logic [31:0] io_wdata;
    logic        e_read;
    logic        base_sel;

    logic [15:0] nsw;
    logic        nbtn;

    int checks = 0;
    int errors = 0;

    io_bus_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .IO_BASE        (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .wdata      (wdata),
        .sw         (sw),
        .btn_confirm(btn_confirm),
        .rdata      (rdata),
        .io_hit     (io_hit),
        .stall      (stall),
        .led_ctrl   (led_ctrl),
        .seg_ctrl   (seg_ctrl),
        .io_wdata   (io_wdata),
        .e_read     (e_read),
        .base_sel   (base_sel)
    );

    // clock / reset values
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // input history seen by the model, one entry per cycle
    bit          rst_h[MAXC];
    bit          btn_h[MAXC];
    logic [15:0] sw_h[MAXC];
    bit          lvl_h[MAXC];

    function automatic bit btn_seen(int c);
        if (c < 2) return 1'b0;
        if (rst_h[c-1] || rst_h[c-2]) return 1'b0;
        return btn_h[c-2];
    endfunction

    function automatic logic [15:0] sw_seen(int c);
        if (c < 2) return 16'h0;
        if (rst_h[c-1] || rst_h[c-2]) return 16'h0;
        return sw_h[c-2];
    endfunction

    // model: a pending switch load, its completion cycle, and the write-side registers
    initial begin : model
        int          k;
        bit          pending;
        bit          completing;
        bit          m_led;
        bit          m_seg;
        bit          m_base;
        logic [31:0] m_cap;
        logic [31:0] m_wd;
        bit          hit;
        bit          rd_any;
        bit          rd_sw;
        bit          e_stall;
        logic [31:0] e_rdata;
        bit          rise;
        bit          flip;
        bit          wr;

        k = 0; pending = 0; completing = 0; m_led = 0; m_seg = 0; m_base = 0;
        m_cap = 0; m_wd = 0;
        lvl_h[0] = 0;
        forever begin
            @(negedge clk);
            #2;
            if (k < MAXC - 1) begin
                rst_h[k] = rst;
                btn_h[k] = btn_confirm;
                sw_h[k]  = sw;
`ifndef IO_DEBOUNCE_EN
                lvl_h[k] = btn_seen(k);
`endif
                hit    = (addr[31:8] == BASE[31:8]);
                rd_any = mem_read && !mem_write && hit;
                rd_sw  = rd_any && addr[7:0] == 8'h00;
                e_stall = pending || (!completing && rd_sw);
                if (completing)                       e_rdata = m_cap;
                else if (rd_any && addr[7:0] == 8'h40) e_rdata = {31'h0, lvl_h[k]};
                else                                   e_rdata = 32'h0;

                chk($sformatf("io_hit@%0d", k),   io_hit,   hit);
                chk($sformatf("stall@%0d", k),    stall,    e_stall);
                chk($sformatf("e_read@%0d", k),   e_read,   pending);
                chk($sformatf("rdata@%0d", k),    rdata,    e_rdata);
                chk($sformatf("led_ctrl@%0d", k), led_ctrl, m_led);
                chk($sformatf("seg_ctrl@%0d", k), seg_ctrl, m_seg);
                chk($sformatf("io_wdata@%0d", k), io_wdata, m_wd);
                chk($sformatf("base_sel@%0d", k), base_sel, m_base);

`ifdef IO_DEBOUNCE_EN
                if (rst) begin
                    lvl_h[k+1] = 0;
                end else begin
                    flip = (k + 1 - DB >= 0);
                    for (int j = k + 1 - DB; j <= k; j++) begin
                        if (j < 0 || rst_h[j] || btn_seen(j) == lvl_h[k]) flip = 0;
                    end
                    lvl_h[k+1] = flip ? !lvl_h[k] : lvl_h[k];
                end
`endif
                if (rst) begin
                    pending = 0; completing = 0; m_led = 0; m_seg = 0; m_base = 0;
                    m_cap = 0; m_wd = 0;
                end else begin
                    wr    = mem_write && hit;
                    rise  = lvl_h[k] && !(k > 0 ? lvl_h[k-1] : 1'b0);
                    m_led = wr && addr[7:0] == 8'h10;
                    m_seg = wr && addr[7:0] == 8'h20;
                    if (m_led || m_seg) m_wd = wdata;
                    if (wr && addr[7:0] == 8'h30) m_base = wdata[0];
                    if (pending) begin
                        if (rise) begin
                            m_cap      = {16'h0, sw_seen(k)};
                            pending    = 0;
                            completing = 1;
                        end
                    end else begin
                        pending    = !completing && rd_sw;
                        completing = 0;
                    end
                end
                k++;
            end
        end
    end

    // driver: applies one cycle of inputs at the falling edge, returns before the rising edge
    task automatic drive(input logic r, input logic [31:0] a, input logic rd, input logic wr,
                         input logic [31:0] wd);
        @(negedge clk);
        rst = r; addr = a; mem_read = rd; mem_write = wr; wdata = wd;
        sw = nsw; btn_confirm = nbtn;
        #3;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 32'h0, 0, 0, 32'h0);
    endtask

    initial begin : stim
        bit done;
        rst = 1; addr = 0; mem_read = 0; mem_write = 0; wdata = 0; sw = 0; btn_confirm = 0;
        nsw = 16'h0; nbtn = 0;
        repeat (3) drive(1, 32'h0, 0, 0, 32'h0);
        drive(0, 32'h0, 0, 0, 32'h0);
        chk("rst_stall", stall, 0);
        chk("rst_e_read", e_read, 0);
        chk("rst_io_wdata", io_wdata, 0);
        chk("rst_base_sel", base_sel, 0);

        // LED store: pulse and data one cycle later
        drive(0, BASE + 32'h10, 0, 1, 32'h0000_ABCD);
        chk("led_pre", led_ctrl, 0);
        idle(1);
        chk("led_pulse", led_ctrl, 1);
        chk("led_seg", seg_ctrl, 0);
        chk("led_data", io_wdata, 32'h0000_ABCD);
        idle(1);
        chk("led_once", led_ctrl, 0);
        chk("led_hold", io_wdata, 32'h0000_ABCD);

        // switch load with a bouncing confirm press
        nsw = 16'h1234;
        idle(2);
        drive(0, BASE, 1, 0, 32'h0);
        chk("load_stall_comb", stall, 1);
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            nbtn = (i == 1) ? 1'b0 : 1'b1;
            drive(0, BASE, 1, 0, 32'h0);
            if (!stall) begin
                done = 1;
                chk("load_done_cycle", i, DONE_I);
                chk("load_rdata", rdata, 32'h0000_1234);
            end
        end
        if (!done) chk("load_timeout", 0, 1);
        idle(1);
        chk("load_after_stall", stall, 0);
        nbtn = 0;
        idle(10);

        // button already held at load time: needs a fresh press
        nbtn = 1; nsw = 16'h00C3;
        idle(10);
        for (int i = 0; i < 8; i++) begin
            drive(0, BASE, 1, 0, 32'h0);
            chk("held_stall", stall, 1);
        end
        nbtn = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, BASE, 1, 0, 32'h0);
            chk("release_stall", stall, 1);
        end
        nbtn = 1;
        done = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            drive(0, BASE, 1, 0, 32'h0);
            if (!stall) begin
                done = 1;
                chk("repress_rdata", rdata, 32'h0000_00C3);
            end
        end
        if (!done) chk("repress_timeout", 0, 1);
        drive(0, BASE + 32'h40, 1, 0, 32'h0);
        chk("btn_status_hi", rdata, 1);
        chk("btn_status_nostall", stall, 0);
        nbtn = 0;
        idle(8);
        drive(0, BASE + 32'h40, 1, 0, 32'h0);
        chk("btn_status_lo", rdata, 0);

        // simultaneous load/store: the store wins
        drive(0, BASE + 32'h20, 1, 1, 32'h7);
        chk("rw_nostall", stall, 0);
        idle(1);
        chk("rw_seg_pulse", seg_ctrl, 1);
        chk("rw_led", led_ctrl, 0);
        chk("rw_data", io_wdata, 32'h7);

        // radix register and an unmapped offset
        drive(0, BASE + 32'h30, 0, 1, 32'h1);
        drive(0, BASE + 32'h50, 1, 0, 32'h0);
        chk("radix_set", base_sel, 1);
        chk("unmapped_rdata", rdata, 0);
        chk("unmapped_hit", io_hit, 1);
        chk("unmapped_stall", stall, 0);
        drive(0, BASE + 32'hFF, 1, 0, 32'h0);
        chk("window_top_hit", io_hit, 1);
        drive(0, BASE + 32'h100, 1, 0, 32'h0);
        chk("window_above_hit", io_hit, 0);
        drive(0, BASE - 32'h1, 1, 0, 32'h0);
        chk("window_below_hit", io_hit, 0);

        // reset aborts a pending load
        nsw = 16'h5A5A;
        repeat (3) drive(0, BASE, 1, 0, 32'h0);
        chk("abort_waiting", e_read, 1);
        drive(1, 32'h0, 0, 0, 32'h0);
        drive(0, 32'h0, 0, 0, 32'h0);
        chk("abort_stall", stall, 0);
        chk("abort_e_read", e_read, 0);
        chk("abort_io_wdata", io_wdata, 0);
        chk("abort_base_sel", base_sel, 0);
        chk("abort_seg", seg_ctrl, 0);
        chk("abort_rdata", rdata, 0);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_bus_ctrl.md
IO_BUS_CTRL -- requirements
Module: io_bus_ctrl

Interface
REQ-001 SHALL take parameter DEBOUNCE_CYCLES, default 20000, meaning the consecutive stable cycles needed before the debounced confirm level changes.
REQ-002 SHALL take parameter IO_BASE, default 32'hFFFF_FC00, meaning the base address of the IO window.
REQ-003 SHALL have one clock and a synchronous, active-high reset; port clk  in  1  system clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 addr  in  32  CPU data address.
REQ-006 mem_read  in  1  CPU load strobe.
REQ-007 mem_write  in  1  CPU store strobe.
REQ-008 wdata  in  32  CPU store data.
REQ-009 sw  in  16  raw board switches.
REQ-010 btn_confirm  in  1  raw confirm pushbutton.
REQ-011 rdata  out  32  load data returned to the CPU.
REQ-012 io_hit  out  1  addr lies in the IO window (combinational).
REQ-013 stall  out  1  CPU hold request.
REQ-014 led_ctrl  out  1  one-cycle LED write pulse.
REQ-015 seg_ctrl  out  1  one-cycle 7-seg write pulse.
REQ-016 io_wdata  out  32  registered store data for the LED/seg stage.
REQ-017 e_read  out  1  high while waiting for user input.
REQ-018 base_sel  out  1  display radix (0 = hex, 1 = dec).

Function
REQ-019 Address map (byte offsets from IO_BASE): 0x00 switches (R), 0x10 LED (W), 0x20 seg (W), 0x30 base_sel (W, bit0), 0x40 debounced button status (R, bit0). Any other offset in the 256-byte window is ignored on writes and reads as 0.
REQ-020 io_hit SHALL be 1 iff addr[31:8] == IO_BASE[31:8].
REQ-021 Store to LED/seg SHALL register wdata into io_wdata and pulse led_ctrl/seg_ctrl for exactly one cycle, with the pulse and data appearing on the next cycle (latency 1).
REQ-022 io_wdata SHALL hold its value until the next accepted LED/seg store.
REQ-023 Store to 0x30 SHALL set base_sel <= wdata[0] on the next edge.
REQ-024 If mem_read and mem_write are both high, the write SHALL be performed and the read ignored.
REQ-025 FSM states SHALL be IDLE, WAIT_PRESS and DONE.
REQ-026 IDLE: a read at 0x00 SHALL move to WAIT_PRESS; stall SHALL go high combinationally in that same cycle.
REQ-027 WAIT_PRESS: stall=1, e_read=1; on the debounced confirm rising edge, capture the synchronized sw into a zero-extended 32-bit register and go to DONE.
REQ-028 DONE: stall=0, rdata=captured value for one cycle, then IDLE.
REQ-029 A button already held when WAIT_PRESS is entered SHALL NOT complete the read; a new rising edge is required.
REQ-030 A read at 0x40 SHALL return the debounced level in the same cycle without stalling.
REQ-031 sw and btn_confirm SHALL pass through 2-flop synchronizers before any use.

Reset
REQ-032 On rst: state=IDLE, stall=0, e_read=0, led_ctrl=0, seg_ctrl=0, io_wdata=0, base_sel=0, captured data=0, debounce counter=0, debounced level=0.
REQ-033 rst asserted mid-WAIT_PRESS SHALL abort the read; stall SHALL be 0 in the cycle after rst.

Configuration
REQ-034 With macro IO_DEBOUNCE_EN defined, the debounced level SHALL change only after the synchronized button has differed from it for DEBOUNCE_CYCLES consecutive cycles; the counter SHALL clear on any bounce.
REQ-035 Without IO_DEBOUNCE_EN, the debounced level SHALL equal the synchronizer output and DEBOUNCE_CYCLES SHALL be unused.

Structure
REQ-036 Package io_pkg SHALL hold the offset constants, the FSM state enum and the default IO_BASE.
REQ-037 The synchronizer, debounce counter and rising-edge detector SHALL form sub-module io_debounce, instantiated once for btn_confirm.

Verification (DEBOUNCE_CYCLES=4)
REQ-038 Store 0x0000_ABCD to IO_BASE+0x10 -> next cycle: led_ctrl=1 for 1 cycle, io_wdata=0x0000_ABCD, seg_ctrl=0.
REQ-039 Load IO_BASE+0x00 with sw=0x1234; press btn with 3-cycle bounce, then hold stable -> stall held until debounced edge; DONE cycle rdata=0x0000_1234; then stall=0.
REQ-040 Button held before load -> stall persists; release, then press again -> read completes.
REQ-041 rst pulse during WAIT_PRESS -> next cycle stall=0, e_read=0, all outputs at reset values.
REQ-042 mem_read=mem_write=1 at IO_BASE+0x20 with wdata=7 -> seg_ctrl pulse, io_wdata=7, no stall.
REQ-043 Store 1 to IO_BASE+0x30, then read IO_BASE+0x50 -> base_sel=1, rdata=0, io_hit=1.
